// File: rtl/frame_loader_if.sv
// Byte-stream input and image-memory write port of the frame loader.
// The loader takes the slave side; the byte source / memory observer takes master.
interface frame_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        we;
    logic [15:0] waddr;
    logic [11:0] wdata;
    logic        busy;
    logic        frame_done;
    logic        err;

    modport master (
        output rx_data, rx_valid,
        input  we, waddr, wdata, busy, frame_done, err
    );

    modport slave (
        input  rx_data, rx_valid,
        output we, waddr, wdata, busy, frame_done, err
    );
endinterface

// File: rtl/frame_loader.sv
// Packs a sync-prefixed byte stream into 12-bit pixels and writes them
// sequentially into the image block memory, with format and idle-timeout aborts.
module frame_loader #(
    parameter int unsigned IMG_W     = 300,
    parameter int unsigned IMG_H     = 200,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 1_000_000
) (
    input  logic          clk,
    input  logic          reset,
    frame_loader_if.slave fl
);

    localparam int unsigned       NUM_PIX   = IMG_W * IMG_H;
    localparam logic [15:0]       LAST_PIX  = 16'(NUM_PIX - 1);
    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        pix_q, pix_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [3:0]         hi_nib_q, hi_nib_d;
    logic               we_q, we_d;
    logic [15:0]        waddr_q, waddr_d;
    logic [11:0]        wdata_q, wdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic in_frame;
    logic timeout_hit;
    logic pix_last;
    logic hdr_bad;
    logic sync_seen;

    // A byte arriving on the TIMEOUT-th idle cycle wins, so the abort requires no strobe.
    assign in_frame    = (state_q != IDLE);
    assign timeout_hit = in_frame && !fl.rx_valid && (idle_q == IDLE_LAST);
    assign pix_last    = (pix_q == LAST_PIX);
    assign hdr_bad     = (fl.rx_data[7:4] != 4'h0);
    assign sync_seen   = fl.rx_valid && (fl.rx_data == SYNC_BYTE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sync_seen) begin
                    state_d = HI;
                end
            end
            HI: begin
                if (fl.rx_valid) begin
                    state_d = hdr_bad ? IDLE : LO;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            LO: begin
                if (fl.rx_valid) begin
                    state_d = pix_last ? IDLE : HI;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pix_d    = pix_q;
        idle_d   = '0;
        hi_nib_d = hi_nib_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        err_d    = err_q;
        busy_d   = (state_d != IDLE);

        if (in_frame) begin
            idle_d = fl.rx_valid ? '0 : idle_q + 1'b1;
            if (timeout_hit) begin
                idle_d = '0;
                err_d  = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (sync_seen) begin
                    pix_d = '0;
                    err_d = 1'b0;
                end
            end
            HI: begin
                if (fl.rx_valid) begin
                    if (hdr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        hi_nib_d = fl.rx_data[3:0];
                    end
                end
            end
            LO: begin
                if (fl.rx_valid) begin
                    we_d    = 1'b1;
                    waddr_d = pix_q;
                    wdata_d = {hi_nib_q, fl.rx_data};
                    if (pix_last) begin
                        done_d = 1'b1;
                    end else begin
                        pix_d = pix_q + 16'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q    <= '0;
            idle_q   <= '0;
            hi_nib_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pix_q    <= pix_d;
            idle_q   <= idle_d;
            hi_nib_q <= hi_nib_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign fl.we         = we_q;
    assign fl.waddr      = waddr_q;
    assign fl.wdata      = wdata_q;
    assign fl.busy       = busy_q;
    assign fl.frame_done = done_q;
    assign fl.err        = err_q;

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader on a 4x2 image with a 16-cycle timeout: directed cases
// plus a random byte stream, all checked cycle by cycle against a frame model.
module tb_frame_loader;

    localparam int unsigned IMG_W   = 4;
    localparam int unsigned IMG_H   = 2;
    localparam int unsigned TIMEOUT = 16;
    localparam int          NPIX    = IMG_W * IMG_H;
    localparam logic [7:0]  SYNC    = 8'hA5;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    frame_loader_if fl();

    frame_loader #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .SYNC_BYTE(SYNC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .fl   (fl)
    );

    int checks  = 0;
    int errors  = 0;
    int weCount = 0;

    // Frame model: whether a frame is open, which byte of the pixel is due,
    // how many pixels are done, and how long the line has been silent.
    bit          mInFrame  = 1'b0;
    bit          mWantHigh = 1'b0;
    bit          mErr      = 1'b0;
    int          mPix      = 0;
    int          mIdle     = 0;
    logic [3:0]  mHiNib    = '0;
    bit          eWe       = 1'b0;
    bit          eDone     = 1'b0;
    logic [15:0] eAddr     = '0;
    logic [11:0] eData     = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    task automatic modelStep(input bit r, input bit v, input logic [7:0] d);
        eWe   = 1'b0;
        eDone = 1'b0;
        if (r) begin
            mInFrame  = 1'b0;
            mWantHigh = 1'b0;
            mPix      = 0;
            mIdle     = 0;
            mErr      = 1'b0;
            eAddr     = '0;
            eData     = '0;
        end else if (!mInFrame) begin
            if (v && d == SYNC) begin
                mInFrame  = 1'b1;
                mWantHigh = 1'b1;
                mPix      = 0;
                mIdle     = 0;
                mErr      = 1'b0;
            end
        end else if (v) begin
            mIdle = 0;
            if (mWantHigh) begin
                if (d[7:4] != 4'h0) begin
                    mInFrame = 1'b0;
                    mErr     = 1'b1;
                end else begin
                    mHiNib    = d[3:0];
                    mWantHigh = 1'b0;
                end
            end else begin
                eWe   = 1'b1;
                eAddr = 16'(mPix);
                eData = {mHiNib, d};
                if (mPix == NPIX - 1) begin
                    eDone    = 1'b1;
                    mInFrame = 1'b0;
                end else begin
                    mPix++;
                    mWantHigh = 1'b1;
                end
            end
        end else begin
            mIdle++;
            if (mIdle == TIMEOUT) begin
                mInFrame = 1'b0;
                mErr     = 1'b1;
                mIdle    = 0;
            end
        end
    endtask

    // One clock: drive inputs, let the edge pass, then compare against the model.
    task automatic applyStimulus(input bit r, input bit v, input logic [7:0] d);
        reset       = r;
        fl.rx_valid = v;
        fl.rx_data  = d;
        @(posedge clk);
        #1;
        modelStep(r, v, d);
        if (fl.we === 1'b1) weCount++;
        checkOutput("we", 32'(fl.we), 32'(eWe));
        checkOutput("frame_done", 32'(fl.frame_done), 32'(eDone));
        checkOutput("busy", 32'(fl.busy), 32'(mInFrame));
        checkOutput("err", 32'(fl.err), 32'(mErr));
        if (eWe || r) begin
            checkOutput("waddr", 32'(fl.waddr), 32'(eAddr));
            checkOutput("wdata", 32'(fl.wdata), 32'(eData));
        end
    endtask

    task automatic sendByte(input logic [7:0] d);
        applyStimulus(1'b0, 1'b1, d);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic sendPixel(input logic [3:0] hi, input logic [7:0] lo);
        sendByte({4'h0, hi});
        sendByte(lo);
    endtask

    function automatic logic [7:0] pickByte();
        logic [7:0] b;
        b = 8'($urandom);
        if (!mInFrame) begin
            if ($urandom_range(0, 2) == 0) b = SYNC;
        end else if (mWantHigh) begin
            if ($urandom_range(0, 19) != 0) b = {4'h0, b[3:0]};
        end else if ($urandom_range(0, 9) == 0) begin
            b = SYNC;
        end
        return b;
    endfunction

    initial begin
        int startCount;
        reset       = 1'b1;
        fl.rx_valid = 1'b0;
        fl.rx_data  = '0;

        $display("[TB] reset with random strobes");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));

        $display("[TB] idle-byte filtering");
        sendByte(8'h00);
        idleCycles(2);
        sendByte(8'hFF);
        sendByte(8'h5A);
        checkOutput("idleBusy", 32'(fl.busy), 32'd0);
        sendByte(SYNC);
        checkOutput("syncBusy", 32'(fl.busy), 32'd1);

        $display("[TB] small frame");
        weCount = 0;
        sendByte(8'h0F);
        sendByte(8'hFF);
        checkOutput("px0data", 32'(fl.wdata), 32'h0FFF);
        checkOutput("px0addr", 32'(fl.waddr), 32'd0);
        sendByte(8'h01);
        sendByte(8'h23);
        checkOutput("px1data", 32'(fl.wdata), 32'h0123);
        for (int p = 2; p < NPIX; p++) begin
            idleCycles($urandom_range(0, 3));
            sendPixel(4'($urandom), 8'($urandom));
        end
        checkOutput("lastAddr", 32'(fl.waddr), 32'(NPIX - 1));
        checkOutput("lastDone", 32'(fl.frame_done), 32'd1);
        idleCycles(1);
        checkOutput("busyDrop", 32'(fl.busy), 32'd0);
        checkOutput("frameWrites", 32'(weCount), 32'(NPIX));

        $display("[TB] format error");
        sendByte(SYNC);
        sendByte(8'h1F);
        checkOutput("fmtNoWrite", 32'(fl.we), 32'd0);
        checkOutput("fmtErr", 32'(fl.err), 32'd1);
        checkOutput("fmtIdle", 32'(fl.busy), 32'd0);
        sendByte(SYNC);
        checkOutput("errCleared", 32'(fl.err), 32'd0);

        $display("[TB] timeout");
        weCount = 0;
        sendPixel(4'hA, 8'hBC);
        idleCycles(TIMEOUT - 1);
        checkOutput("preTimeoutBusy", 32'(fl.busy), 32'd1);
        idleCycles(1);
        checkOutput("timeoutErr", 32'(fl.err), 32'd1);
        checkOutput("timeoutBusy", 32'(fl.busy), 32'd0);
        checkOutput("timeoutWrites", 32'(weCount), 32'd1);
        sendByte(SYNC);
        sendPixel(4'h1, 8'h11);
        idleCycles(TIMEOUT - 1);
        sendByte(8'h02);
        checkOutput("lateByteBusy", 32'(fl.busy), 32'd1);
        checkOutput("lateByteErr", 32'(fl.err), 32'd0);
        idleCycles(TIMEOUT);
        checkOutput("loTimeoutErr", 32'(fl.err), 32'd1);

        $display("[TB] reset mid-frame");
        sendByte(SYNC);
        for (int p = 0; p < 3; p++) sendPixel(4'($urandom), 8'($urandom));
        sendByte(8'h01);
        applyStimulus(1'b1, 1'b1, 8'h55);
        startCount = weCount;
        sendByte(8'h0F);
        sendByte(8'hFF);
        sendByte(8'h03);
        checkOutput("postResetWrites", 32'(weCount - startCount), 32'd0);

        $display("[TB] random stream");
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 5)        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
            else if (r < 25)  idleCycles(int'($urandom_range(TIMEOUT - 2, TIMEOUT + 1)));
            else if (r < 450) applyStimulus(1'b0, 1'b0, 8'($urandom));
            else              sendByte(pickByte());
        end

        $display("[TB] back-to-back frame and restart");
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendByte(SYNC);
        weCount = 0;
        for (int p = 0; p < NPIX; p++) sendPixel(4'($urandom), 8'($urandom));
        checkOutput("b2bLastAddr", 32'(fl.waddr), 32'(NPIX - 1));
        checkOutput("b2bDone", 32'(fl.frame_done), 32'd1);
        checkOutput("b2bWrites", 32'(weCount), 32'(NPIX));
        sendByte(SYNC);
        sendPixel(4'h7, 8'h89);
        checkOutput("restartAddr", 32'(fl.waddr), 32'd0);
        checkOutput("restartData", 32'(fl.wdata), 32'h0789);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
